// File: rtl/seg_anim_decoder.sv
// seg_anim_decoder
// Debounces a live 7-segment pattern against a periodic sample strobe and
// decodes each newly stable pattern into a hex digit, buffered in a small FIFO.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   enable     sampling enable; low freezes cand/count/state (FIFO still drains)
//   tick       one-cycle sample strobe
//   seg_in     live segment pattern, seg_in[0]=a .. seg_in[6]=g
//   out_valid  FIFO head entry available
//   out_ready  consumer accepts head entry
//   out_data   decoded hex digit of head entry
//   out_err    head entry came from an undecodable pattern
//   overflow   sticky: an entry was dropped on a full FIFO
//   busy       stability tracker is in TRACK
module seg_anim_decoder #(
  parameter int STABLE_TICKS = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic [6:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_err,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    ST_L    = 4'(STABLE_TICKS);
  localparam logic [CW-1:0] DEPTH_L = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED} state_t;

  state_t      r_state, w_state_nxt;
  logic [6:0]  r_cand, w_cand_nxt;
  logic [3:0]  r_count, w_count_nxt;
  logic        w_sample, w_accept;
  logic [3:0]  w_dec_data;
  logic        w_dec_err;

  assign w_sample = tick & enable;

  // ---------------- stability tracker ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cand  <= 7'h00;
      r_count <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    if (w_sample) begin
      if (seg_in != r_cand) begin
        // New candidate from any state; with a one-tick threshold the first
        // sample is already stable.
        w_cand_nxt  = seg_in;
        w_count_nxt = 4'd1;
        if (STABLE_TICKS == 1) begin
          w_state_nxt = S_LOCKED;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_TRACK;
        end
      end else if (r_state == S_TRACK) begin
        w_count_nxt = r_count + 4'd1;
        if (r_count + 4'd1 == ST_L) begin
          w_state_nxt = S_LOCKED;
          w_accept    = 1'b1;
        end
      end
      // IDLE/LOCKED with an equal sample: nothing, so no repeat emission.
    end
  end

  assign busy = (r_state == S_TRACK);

  // ---------------- pattern decoder ----------------
  always_comb begin
    w_dec_data = 4'h0;
    w_dec_err  = 1'b0;
    case (w_cand_nxt)
      7'h3F: w_dec_data = 4'h0;
      7'h06: w_dec_data = 4'h1;
      7'h5B: w_dec_data = 4'h2;
      7'h4F: w_dec_data = 4'h3;
      7'h66: w_dec_data = 4'h4;
      7'h6D: w_dec_data = 4'h5;
      7'h7D: w_dec_data = 4'h6;
      7'h07: w_dec_data = 4'h7;
      7'h7F: w_dec_data = 4'h8;
      7'h6F: w_dec_data = 4'h9;
      7'h77: w_dec_data = 4'hA;
      7'h7C: w_dec_data = 4'hB;
      7'h39: w_dec_data = 4'hC;
      7'h5E: w_dec_data = 4'hD;
      7'h79: w_dec_data = 4'hE;
      7'h71: w_dec_data = 4'hF;
      default: w_dec_err = 1'b1;
    endcase
  end

  // ---------------- output FIFO ----------------
  logic [4:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop, w_full, w_wr;

  // A blank acceptance only re-arms the tracker; it never enters the FIFO.
  assign w_push = w_accept && (w_cand_nxt != 7'h00);
  assign w_pop  = out_valid && out_ready;
  assign w_full = (r_cnt == DEPTH_L);
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 5'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= {w_dec_err, w_dec_data};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
      if (w_push && !w_wr) overflow <= 1'b1;
    end
  end

  assign out_valid = (r_cnt != '0);
  assign out_data  = out_valid ? r_mem[r_rd][3:0] : 4'h0;
  assign out_err   = out_valid ? r_mem[r_rd][4]   : 1'b0;

endmodule

// File: tb/tb_seg_anim_decoder.sv
// Directed bench for seg_anim_decoder: a vector table of held patterns with
// expected emissions, plus hand sequences for latency, FIFO full/overflow,
// enable freeze and asynchronous reset.
module tb_seg_anim_decoder;

  logic       clk = 1'b0;
  logic       reset, enable, tick, out_ready;
  logic [6:0] seg_in;
  logic       out_valid, out_err, overflow, busy;
  logic [3:0] out_data;

  seg_anim_decoder #(.STABLE_TICKS(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick), .seg_in(seg_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transfers observed: {err,data} for every cycle with valid & ready.
  logic [4:0] rx_q[$];
  always @(negedge clk)
    if (!reset && out_valid && out_ready) rx_q.push_back({out_err, out_data});

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // n qualifying samples of s, each followed by one idle cycle.
  task automatic ticks(input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      seg_in = s; tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
    rx_q.delete();
  endtask

  function automatic int rx_at(input int i);
    return (rx_q.size() > i) ? int'(rx_q[i]) : -1;
  endfunction

  typedef struct {
    logic [6:0] seg;
    int         n;
    int         exp_cnt;
    int         exp_val;   // {err,data}
  } vec_t;

  vec_t vt[20];

  initial begin
    vt[0]  = '{7'h5B, 3, 1, 5'h02};
    vt[1]  = '{7'h06, 2, 0, 0};
    vt[2]  = '{7'h7F, 3, 1, 5'h08};
    vt[3]  = '{7'h4F, 6, 1, 5'h03};
    vt[4]  = '{7'h00, 3, 0, 0};
    vt[5]  = '{7'h4F, 3, 1, 5'h03};
    vt[6]  = '{7'h01, 3, 1, 5'h10};
    vt[7]  = '{7'h71, 2, 0, 0};
    vt[8]  = '{7'h71, 1, 1, 5'h0F};
    vt[9]  = '{7'h77, 3, 1, 5'h0A};
    vt[10] = '{7'h7C, 3, 1, 5'h0B};
    vt[11] = '{7'h39, 3, 1, 5'h0C};
    vt[12] = '{7'h5E, 3, 1, 5'h0D};
    vt[13] = '{7'h79, 3, 1, 5'h0E};
    vt[14] = '{7'h3F, 3, 1, 5'h00};
    vt[15] = '{7'h6F, 4, 1, 5'h09};
    vt[16] = '{7'h66, 3, 1, 5'h04};
    vt[17] = '{7'h6D, 3, 1, 5'h05};
    vt[18] = '{7'h7D, 3, 1, 5'h06};
    vt[19] = '{7'h07, 3, 1, 5'h07};

    reset = 1'b1; enable = 1'b1; tick = 1'b0; out_ready = 1'b1; seg_in = 7'h00;
    cyc(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_err",   out_err,   0);
    chk("rst_ovf",   overflow,  0);
    chk("rst_busy",  busy,      0);
    reset = 1'b0; cyc(1);

    // Latency: entry visible the cycle after the 3rd tick, gone after pop.
    ticks(7'h5B, 2);
    chk("lat_busy", busy, 1);
    seg_in = 7'h5B; tick = 1'b1;
    @(negedge clk);
    chk("lat_pre_valid", out_valid, 0);
    @(posedge clk); #1; tick = 1'b0;
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_data",  out_data,  2);
    chk("lat_err",   out_err,   0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_post_valid", out_valid, 0);
    chk("lat_post_busy",  busy,      0);
    cyc(1);

    // Vector table.
    do_reset();
    for (int v = 0; v < 20; v++) begin
      rx_q.delete();
      ticks(vt[v].seg, vt[v].n);
      cyc(2);
      chk($sformatf("vec%0d_cnt", v), rx_q.size(), vt[v].exp_cnt);
      if (vt[v].exp_cnt > 0) chk($sformatf("vec%0d_val", v), rx_at(0), vt[v].exp_val);
    end

    // Push at full with simultaneous pop: accepted, no overflow.
    do_reset();
    out_ready = 1'b0;
    ticks(7'h3F, 3); ticks(7'h06, 3); ticks(7'h5B, 3); ticks(7'h4F, 3);
    chk("full_head", out_data, 0);
    ticks(7'h66, 2);
    seg_in = 7'h66; tick = 1'b1; out_ready = 1'b1; cyc(1);
    tick = 1'b0; out_ready = 1'b0; cyc(1);
    chk("pp_ovf", overflow, 0);
    out_ready = 1'b1; cyc(8);
    chk("pp_cnt", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("pp_ord%0d", i), rx_at(i), i);
    chk("pp_ovf_end", overflow, 0);

    // Push at full without pop: dropped, sticky overflow.
    out_ready = 1'b0;
    ticks(7'h6D, 3); ticks(7'h7D, 3); ticks(7'h07, 3); ticks(7'h7F, 3);
    chk("of_pre", overflow, 0);
    ticks(7'h6F, 3);
    chk("of_set", overflow, 1);
    rx_q.delete();
    out_ready = 1'b1; cyc(8);
    chk("of_cnt", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("of_ord%0d", i), rx_at(i), 5 + i);
    chk("of_sticky", overflow, 1);

    // enable=0 freezes the tracker but not the FIFO drain.
    do_reset();
    out_ready = 1'b0;
    ticks(7'h06, 3);
    enable = 1'b0; out_ready = 1'b1; rx_q.delete();
    ticks(7'h5B, 3); ticks(7'h3F, 2);
    chk("en_busy", busy, 0);
    chk("en_cnt", rx_q.size(), 1);
    chk("en_val", rx_at(0), 1);
    enable = 1'b1;
    ticks(7'h06, 3);   // still locked on 06: no tracking, no repeat
    chk("en_frozen_busy", busy, 0);
    chk("en_frozen_cnt", rx_q.size(), 1);

    // Async reset mid-TRACK discards the partial pattern.
    do_reset();
    ticks(7'h66, 2);
    chk("rm_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("rm_valid", out_valid, 0);
    chk("rm_data",  out_data,  0);
    chk("rm_err",   out_err,   0);
    chk("rm_ovf",   overflow,  0);
    chk("rm_busy0", busy,      0);
    cyc(2); reset = 1'b0; cyc(1); rx_q.delete();
    ticks(7'h66, 1); cyc(3);
    chk("rm_no_entry", rx_q.size(), 0);
    chk("rm_restart_busy", busy, 1);
    ticks(7'h66, 2); cyc(2);
    chk("rm_entry_cnt", rx_q.size(), 1);
    chk("rm_entry_val", rx_at(0), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
